// File: rtl/lab2_hazard_seq.sv
// lab2_hazard_seq
// Stimulus sequencer for the hazard lab circuit Y = AB'C + C'D and its
// hazard-free variants Y1/Y2. A run walks all 16 input vectors in Gray-code
// order (one input changes per step), lets each settle for SETTLE cycles,
// then samples y/y1/y2 against a golden model and counts mismatches.
//
// Optional build macro: HAZARD_GLITCH_MON_EN
//   When defined, a monitor counts settle windows with 2+ edges on y_in.
//   When undefined, glitch_cnt is tied to 0.
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   start               level run request, honoured only in IDLE
//   y_in, y1_in, y2_in  outputs of the circuit under test
//   a, b, c, d          registered stimulus (a = MSB of Gray vector)
//   busy                high in every state but IDLE
//   done                one-cycle pulse when a run completes
//   err_y/err_y1/err_y2 saturating mismatch counts per DUT output
//   glitch_cnt          saturating count of glitchy settle windows
module lab2_hazard_seq #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             y_in,
  input  logic             y1_in,
  input  logic             y2_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_y,
  output logic [CNT_W-1:0] err_y1,
  output logic [CNT_W-1:0] err_y2,
  output logic [CNT_W-1:0] glitch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  localparam logic [7:0]       SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state, state_nx;
  logic [3:0] idx;
  logic [7:0] settle_cnt;
  logic       exp_y;
  logic       run_go;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  // Golden response computed from the vector currently being driven.
  assign exp_y  = (a & ~b & c) | (~c & d);
  assign run_go = (state == S_IDLE) && start;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_DRIVE;
      S_DRIVE:  state_nx = S_SETTLE;
      S_SETTLE: if (settle_cnt == 8'd0) state_nx = S_SAMPLE;
      S_SAMPLE: state_nx = (idx == 4'd15) ? S_DONE : S_DRIVE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      {a, b, c, d} <= 4'b0000;
      err_y      <= '0;
      err_y1     <= '0;
      err_y2     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          idx    <= '0;
          err_y  <= '0;
          err_y1 <= '0;
          err_y2 <= '0;
        end
        S_DRIVE: begin
          {a, b, c, d} <= idx ^ (idx >> 1);
          settle_cnt   <= SETTLE_LD;
        end
        S_SETTLE: if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        S_SAMPLE: begin
          err_y  <= sat_inc(err_y,  y_in  != exp_y);
          err_y1 <= sat_inc(err_y1, y1_in != exp_y);
          err_y2 <= sat_inc(err_y2, y2_in != exp_y);
          if (idx != 4'd15) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_GLITCH_MON_EN
  // Edge counter over the settle window. The first SETTLE cycle compares
  // against y_in from the DRIVE cycle, so the legitimate output change
  // counts as one edge; a hazard pulse adds two more.
  logic       y_q;
  logic [1:0] edge_cnt;
  logic [CNT_W-1:0] glitch_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q      <= 1'b0;
      edge_cnt <= 2'd0;
      glitch_r <= '0;
    end else begin
      y_q <= y_in;
      if (run_go) glitch_r <= '0;
      case (state)
        S_DRIVE:  edge_cnt <= 2'd0;
        S_SETTLE: if (y_in != y_q && edge_cnt != 2'd3) edge_cnt <= edge_cnt + 2'd1;
        S_SAMPLE: glitch_r <= sat_inc(glitch_r, edge_cnt >= 2'd2);
        default: ;
      endcase
    end
  end

  assign glitch_cnt = glitch_r;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_lab2_hazard_seq.sv
// Directed bench for lab2_hazard_seq: zero-delay model of the hazard
// circuit with switchable stuck-at-0 and glitch injection on y_in.
module tb_lab2_hazard_seq;

  localparam int CNT_W = 5;

  logic clk = 1'b0, clk_en = 1'b0;
  logic reset, start;
  logic stuck = 1'b0, glitch = 1'b0;
  logic a, b, c, d, busy, done;
  logic y_in, y1_in, y2_in, y_mod;
  logic [CNT_W-1:0] err_y, err_y1, err_y2, glitch_cnt;

  int passed = 0, failed = 0, total = 0;
  int n;
  logic [3:0] vec [16];
  logic [3:0] gray_ref [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
`ifdef HAZARD_GLITCH_MON_EN
  localparam int GLITCH_EXP = 1;
`else
  localparam int GLITCH_EXP = 0;
`endif

  always #5 if (clk_en) clk = ~clk;

  assign y_mod = (a & ~b & c) | (~c & d);
  assign y_in  = (stuck || glitch) ? 1'b0 : y_mod;
  assign y1_in = y_mod | (a & ~b & d);
  assign y2_in = y_mod | (a & ~b & d);

  lab2_hazard_seq #(.SETTLE(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .y_in(y_in), .y1_in(y1_in), .y2_in(y2_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .err_y(err_y), .err_y1(err_y1), .err_y2(err_y2), .glitch_cnt(glitch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " abcd"}, {a, b, c, d}, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err_y"}, err_y, 0);
    check({tag, " err_y1"}, err_y1, 0);
    check({tag, " err_y2"}, err_y2, 0);
    check({tag, " glitch"}, glitch_cnt, 0);
  endtask

  // Caller sets start at a negedge; the next posedge is edge t.
  // Returns the cycle (counted from t) in which done is seen, 0 on timeout.
  task automatic run_to_done(input bit hold, input int pulse_at,
                             input int glitch_at, output int nd);
    nd = 0;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start  = hold || (k == pulse_at);
      glitch = (k == glitch_at);
      if (k % 6 == 2 && k < 98) vec[(k-2)/6] = {a, b, c, d};
      if (done) begin
        nd = k;
        break;
      end
    end
    glitch = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    #5;
    check_zero("reset_noclk");

    clk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
    end

    // Run A: correct circuit, stray start pulse mid-run
    start = 1'b1;
    run_to_done(1'b0, 30, -1, n);
    check("runA_done_cycle", n, 97);
    check("runA_err_y", err_y, 0);
    check("runA_err_y1", err_y1, 0);
    check("runA_err_y2", err_y2, 0);
    check("runA_glitch", glitch_cnt, 0);
    for (int i = 0; i < 16; i++) check("runA_gray_vec", vec[i], gray_ref[i]);

    // Run B: y stuck at 0, start held high for back-to-back restart
    @(negedge clk);
    stuck = 1'b1;
    start = 1'b1;
    run_to_done(1'b1, -1, -1, n);
    check("runB_done_cycle", n, 97);
    check("runB_err_y", err_y, 6);
    check("runB_err_y1", err_y1, 0);
    check("runB_err_y2", err_y2, 0);
    @(negedge clk);
    check("restart_idle_busy", busy, 0);
    check("restart_idle_done", done, 0);
    check("restart_hold_err_y", err_y, 6);

    // Run C starts from the held start; reset during vector 7 settle
    @(negedge clk);
    start = 1'b0;
    check("runC_drive_busy", busy, 1);
    check("runC_cleared_err_y", err_y, 0);
    repeat (43) @(negedge clk);
    check("runC_vec7", {a, b, c, d}, 4'h4);
    check("runC_partial_err_y", err_y, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    stuck = 1'b0;
    check("post_reset_busy", busy, 0);

    // Run D: glitch pulse inside the settle window of vector 1011
    @(negedge clk);
    start = 1'b1;
    run_to_done(1'b0, -1, 81, n);
    check("runD_done_cycle", n, 97);
    check("runD_err_y", err_y, 0);
    check("runD_err_y1", err_y1, 0);
    check("runD_glitch", glitch_cnt, GLITCH_EXP);
    @(negedge clk);
    check("runD_idle_busy", busy, 0);
    check("runD_hold_glitch", glitch_cnt, GLITCH_EXP);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
